// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Front-end for a single-clock sync RAM (one write port, one registered
//   read port with 1-cycle latency). Shares the read port between rd0
//   (display scan) and rd1 (host) and arbitrates the write port between
//   host writes and a clear engine that fills addresses 0..CLEAR_DEPTH-1
//   with FILL_VALUE.
//
//   Optional build macro ARB_FIXED_PRIO_EN: rd0 always wins read ties and
//   the round-robin pointer is removed. Default build is round-robin.
//
//   Handshake semantics: a requester raises rdX_req/wr_req with its
//   address/data and holds all of them stable until the matching
//   rdX_gnt/wr_ack is seen high in the same cycle; that cycle is the
//   transfer. Read data returns on rdX_valid exactly one cycle after the
//   grant and is only meaningful while rdX_valid is high.
module ram_access_arbiter #(
    parameter int                    ADDR_WIDTH  = 13,
    parameter int                    DATA_WIDTH  = 7,
    parameter int                    CLEAR_DEPTH = 2 ** ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // clear engine
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    // host write
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    // read requesters
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_gnt,
    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_gnt,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,
    // RAM side
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    // debug: current write FSM state (0 = IDLE, 1 = CLEAR)
    output logic                  dbg_wr_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } wr_state_t;

    // One extra bit so a clear of 2**ADDR_WIDTH words reaches its last index
    // without the counter wrapping.
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(CLEAR_DEPTH - 1);

    wr_state_t             state_q;
    wr_state_t             state_d;
    logic [ADDR_WIDTH:0]   clr_cnt_q;
    logic                  clr_done_q;
    logic                  rd0_valid_q;
    logic                  rd1_valid_q;
    logic                  clr_last;

    assign clr_last = (state_q == S_CLEAR) && (clr_cnt_q == CLR_LAST);

    // ------------------------------------------------------------------
    // Read arbitration
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: rd0 wins every tie, rd1 only when rd0 is idle.
    always_comb begin
        rd0_gnt = rd0_req;
        rd1_gnt = rd1_req && !rd0_req;
    end
`else
    logic last_rd1_q;  // 1 when rd1 received the most recent grant

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        rd0_gnt = rd0_req && (!rd1_req || last_rd1_q);
        rd1_gnt = rd1_req && (!rd0_req || !last_rd1_q);
    end

    // Pointer moves only when someone is granted; reset favours rd0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd1_q <= 1'b1;
        end else if (rd0_gnt) begin
            last_rd1_q <= 1'b0;
        end else if (rd1_gnt) begin
            last_rd1_q <= 1'b1;
        end
    end
`endif

    // Granted address steers the read port; rd0_addr when nobody is granted.
    always_comb begin
        ram_addr_r = rd1_gnt ? rd1_addr : rd0_addr;
    end

    // Valid follows the grant by one cycle, matching the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            rd0_valid_q <= rd0_gnt;
            rd1_valid_q <= rd1_gnt;
        end
    end

    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;
    assign rd0_data  = ram_dout;
    assign rd1_data  = ram_dout;

    // ------------------------------------------------------------------
    // Write FSM: IDLE serves host writes, CLEAR walks the fill counter
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: clr_start only matters in IDLE; CLEAR ends after the last index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clr_start) state_d = S_CLEAR;
            S_CLEAR: if (clr_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: host owns the write port in IDLE, the clear engine in CLEAR.
    always_comb begin
        ram_we     = 1'b0;
        ram_addr_w = wr_addr;
        ram_din    = wr_data;
        wr_ack     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ram_we = wr_req;
                wr_ack = wr_req;
            end
            S_CLEAR: begin
                ram_we     = 1'b1;
                ram_addr_w = clr_cnt_q[ADDR_WIDTH-1:0];
                ram_din    = FILL_VALUE;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Clear address counter: held at zero outside CLEAR so each clear starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else if (state_q == S_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end else begin
            clr_cnt_q <= '0;
        end
    end

    // Done pulse in the cycle after the final clear write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= clr_last;
        end
    end

    assign clr_busy     = (state_q == S_CLEAR);
    assign clr_done     = clr_done_q;
    assign dbg_wr_state = state_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
//   Bench for ram_access_arbiter with a behavioural sync RAM attached.
//   Reference model: an array holding the expected RAM contents, a count of
//   clear writes still owed, a round-robin preference bit and per-requester
//   expected-data queues. Build with +define+ARB_FIXED_PRIO_EN to check the
//   fixed-priority variant.
module tb_ram_access_arbiter;

  localparam int AW = 8;
  localparam int DW = 7;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] FILL = 7'h20;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          clr_start, clr_busy, clr_done;
  logic          wr_req, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd0_req, rd0_gnt, rd0_valid;
  logic [AW-1:0] rd0_addr;
  logic [DW-1:0] rd0_data;
  logic          rd1_req, rd1_gnt, rd1_valid;
  logic [AW-1:0] rd1_addr;
  logic [DW-1:0] rd1_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic [DW-1:0] ram_din, ram_dout;
  logic          dbg_wr_state;

  ram_access_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLEAR_DEPTH(DEPTH),
    .FILL_VALUE (FILL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd0_req     (rd0_req),
    .rd0_addr    (rd0_addr),
    .rd0_gnt     (rd0_gnt),
    .rd0_valid   (rd0_valid),
    .rd0_data    (rd0_data),
    .rd1_req     (rd1_req),
    .rd1_addr    (rd1_addr),
    .rd1_gnt     (rd1_gnt),
    .rd1_valid   (rd1_valid),
    .rd1_data    (rd1_data),
    .ram_we      (ram_we),
    .ram_addr_w  (ram_addr_w),
    .ram_din     (ram_din),
    .ram_addr_r  (ram_addr_r),
    .ram_dout    (ram_dout),
    .dbg_wr_state(dbg_wr_state)
  );

  // ---------------- behavioural RAM (read-before-write) ----------------
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    ram_dout <= tb_mem[ram_addr_r];
    if (ram_we) tb_mem[ram_addr_w] = ram_din;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  int            m_clr_left;   // clear writes still to be performed
  logic          m_done;       // done pulse expected now
  logic          m_last_rd1;   // rd1 was granted most recently
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_done_seen = 0;
  int n_busy_seen = 0;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clr_left = 0;
    m_done     = 1'b0;
    m_last_rd1 = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Drive-in-place reset: asynchronous assert, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_rd0_valid", 32'(rd0_valid), 32'd0);
    check("rst_rd1_valid", 32'(rd1_valid), 32'd0);
    check("rst_state", 32'(dbg_wr_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- one clock cycle with checks ----------------
  // Caller sets inputs at a falling edge; this checks the combinational
  // response, advances the model across the rising edge and checks the
  // registered outputs at the next falling edge.
  task automatic step(output logic og0, output logic og1, output logic oack);
    logic          g0, g1, we, ack;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    #1;
`ifdef ARB_FIXED_PRIO_EN
    g0 = rd0_req;
    g1 = rd1_req && !rd0_req;
`else
    if (rd0_req && rd1_req) begin
      g0 = m_last_rd1;
      g1 = !m_last_rd1;
    end else begin
      g0 = rd0_req;
      g1 = rd1_req;
    end
`endif
    if (m_clr_left > 0) begin
      we  = 1'b1;
      wa  = AW'(DEPTH - m_clr_left);
      wd  = FILL;
      ack = 1'b0;
    end else begin
      we  = wr_req;
      wa  = wr_addr;
      wd  = wr_data;
      ack = wr_req;
    end
    ra = g1 ? rd1_addr : rd0_addr;
    check("rd0_gnt", 32'(rd0_gnt), 32'(g0));
    check("rd1_gnt", 32'(rd1_gnt), 32'(g1));
    check("wr_ack", 32'(wr_ack), 32'(ack));
    check("ram_we", 32'(ram_we), 32'(we));
    if (we) begin
      check("ram_addr_w", 32'(ram_addr_w), 32'(wa));
      check("ram_din", 32'(ram_din), 32'(wd));
    end
    if (g0 || g1) check("ram_addr_r", 32'(ram_addr_r), 32'(ra));
    @(posedge clk);
    if (g0) exp_q0.push_back(m_mem[ra]);
    if (g1) exp_q1.push_back(m_mem[ra]);
    if (we) m_mem[wa] = wd;
    m_done = (m_clr_left == 1);
    if (m_clr_left > 0) m_clr_left--;
    else if (clr_start) m_clr_left = DEPTH;
    if (g0) m_last_rd1 = 1'b0;
    else if (g1) m_last_rd1 = 1'b1;
    @(negedge clk);
    check("rd0_valid", 32'(rd0_valid), 32'(exp_q0.size() > 0));
    if (rd0_valid && exp_q0.size() > 0) check("rd0_data", 32'(rd0_data), 32'(exp_q0.pop_front()));
    else exp_q0.delete();
    check("rd1_valid", 32'(rd1_valid), 32'(exp_q1.size() > 0));
    if (rd1_valid && exp_q1.size() > 0) check("rd1_data", 32'(rd1_data), 32'(exp_q1.pop_front()));
    else exp_q1.delete();
    check("clr_busy", 32'(clr_busy), 32'(m_clr_left > 0));
    check("clr_done", 32'(clr_done), 32'(m_done));
    if (clr_done) n_done_seen++;
    if (clr_busy) n_busy_seen++;
    og0  = g0;
    og1  = g1;
    oack = ack;
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    clr_start = 1'b0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd0_req   = 1'b0;
    rd0_addr  = '0;
    rd1_req   = 1'b0;
    rd1_addr  = '0;
  endtask

  task automatic read0(input logic [AW-1:0] a);
    logic g0, g1, ack;
    idle_inputs();
    rd0_req  = 1'b1;
    rd0_addr = a;
    step(g0, g1, ack);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic g0, g1, ack;
    idle_inputs();
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(g0, g1, ack);
  endtask

  // Runs idle cycles until the model says the clear is over (bounded).
  task automatic wait_clear_end();
    logic g0, g1, ack;
    idle_inputs();
    for (int i = 0; i < 40 && m_clr_left > 0; i++) step(g0, g1, ack);
    check("clear_finished", 32'(m_clr_left), 32'd0);
    step(g0, g1, ack);
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic g0, g1, ack;
    logic p0, p1, pw;
    int   busy_start, done_start, ack_cycle;

    for (int i = 0; i < (1 << AW); i++) begin
      tb_mem[i] = DW'($urandom);
      m_mem[i]  = tb_mem[i];
    end
    tb_mem[8'h81] = 7'h32;
    m_mem[8'h81]  = 7'h32;
    tb_mem[8'h05] = 7'h0c;
    m_mem[8'h05]  = 7'h0c;

    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: single rd0 read of preloaded word
    read0(8'h81);
    check("t1_rd0_data", 32'(rd0_data), 32'h32);
    check("t1_rd1_valid", 32'(rd1_valid), 32'd0);

    // 2: both requesters held for 4 cycles from a fresh pointer
    do_reset();
    idle_inputs();
    rd0_req  = 1'b1;
    rd0_addr = 8'h10;
    rd1_req  = 1'b1;
    rd1_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step(g0, g1, ack);
`ifdef ARB_FIXED_PRIO_EN
      check("t2_rd0_valid", 32'(rd0_valid), 32'd1);
`else
      check("t2_rd0_valid", 32'(rd0_valid), 32'(i % 2 == 0));
      check("t2_rd1_valid", 32'(rd1_valid), 32'(i % 2 == 1));
`endif
    end

    // 3: write 0x41 to 0x005 with same-cycle rd1 read, then read it back
    idle_inputs();
    wr_req   = 1'b1;
    wr_addr  = 8'h05;
    wr_data  = 7'h41;
    rd1_req  = 1'b1;
    rd1_addr = 8'h05;
    step(g0, g1, ack);
    check("t3_same_cycle_old", 32'(rd1_data), 32'h0c);
    idle_inputs();
    rd1_req  = 1'b1;
    rd1_addr = 8'h05;
    step(g0, g1, ack);
    check("t3_readback", 32'(rd1_data), 32'h41);

    // 4: clear pulse with a host write held across it
    busy_start = n_busy_seen;
    done_start = n_done_seen;
    idle_inputs();
    clr_start = 1'b1;
    step(g0, g1, ack);
    clr_start = 1'b0;
    wr_req    = 1'b1;
    wr_addr   = 8'h30;
    wr_data   = 7'h55;
    ack_cycle = -1;
    for (int i = 1; i <= 40; i++) begin
      step(g0, g1, ack);
      if (ack) begin
        ack_cycle = i;
        break;
      end
    end
    check("t4_busy_cycles", 32'(n_busy_seen - busy_start), 32'd16);
    check("t4_done_pulses", 32'(n_done_seen - done_start), 32'd1);
    check("t4_ack_cycle", 32'(ack_cycle), 32'd17);
    for (int a = 0; a < DEPTH; a++) begin
      read0(AW'(a));
      check("t4_fill_read", 32'(rd0_data), 32'(FILL));
    end

    // 5: clr_start together with a host write in IDLE
    host_write(8'h03, 7'h11);
    idle_inputs();
    clr_start = 1'b1;
    wr_req    = 1'b1;
    wr_addr   = 8'h03;
    wr_data   = 7'h11;
    step(g0, g1, ack);
    check("t5_ack_first", 32'(ack), 32'd1);
    wait_clear_end();
    read0(8'h03);
    check("t5_filled", 32'(rd0_data), 32'(FILL));

    // 6: reset during clear cycle 7, then restart
    for (int a = 0; a < 8; a++) host_write(AW'(a), DW'(7'h50 + a));
    done_start = n_done_seen;
    idle_inputs();
    clr_start = 1'b1;
    step(g0, g1, ack);
    clr_start = 1'b0;
    for (int i = 0; i < 6; i++) step(g0, g1, ack);
    do_reset();
    idle_inputs();
    for (int i = 0; i < 20; i++) step(g0, g1, ack);
    check("t6_no_done", 32'(n_done_seen - done_start), 32'd0);
    for (int a = 0; a < 8; a++) read0(AW'(a));
    check("t6_partial_last", 32'(rd0_data), 32'h57);
    idle_inputs();
    clr_start = 1'b1;
    step(g0, g1, ack);
    clr_start = 1'b0;
    wait_clear_end();
    check("t6_restart_done", 32'(n_done_seen - done_start), 32'd1);

    // 7: randomized traffic
    p0 = 1'b0;
    p1 = 1'b0;
    pw = 1'b0;
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1;
        rd0_addr = AW'($urandom_range(0, 31));
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        rd1_addr = AW'($urandom_range(0, 31));
      end
      if (!pw && $urandom_range(0, 3) == 0) begin
        pw = 1'b1;
        wr_addr = AW'($urandom_range(0, 31));
        wr_data = DW'($urandom);
      end
      rd0_req   = p0;
      rd1_req   = p1;
      wr_req    = pw;
      clr_start = ($urandom_range(0, 59) == 0);
      step(g0, g1, ack);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
      if (ack) pw = 1'b0;
    end
    wait_clear_end();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Controller sitting in front of the single-clock sync RAM (one write port, one registered read port, 1-cycle read latency).
- Shares the read port between two requesters: rd0 (display scan) and rd1 (host).
- Arbitrates the write port between host writes and an internal clear engine that fills the whole RAM with a constant.
- Instantiated alongside the RAM; drives all RAM control/address/data inputs.

Parameters:
- ADDR_WIDTH, 13, RAM address bits.
- DATA_WIDTH, 7, RAM word bits.
- CLEAR_DEPTH, 2**ADDR_WIDTH, number of words written by a clear (addresses 0..CLEAR_DEPTH-1).
- FILL_VALUE, 0 (DATA_WIDTH bits), word written by the clear engine.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clr_start  in  1  request full clear; single-cycle pulse or level.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse after the last clear write.
- wr_req  in  1  host write request.
- wr_addr  in  ADDR_WIDTH  host write address.
- wr_data  in  DATA_WIDTH  host write data.
- wr_ack  out  1  host write accepted this cycle.
- rd0_req / rd1_req  in  1  read request per requester.
- rd0_addr / rd1_addr  in  ADDR_WIDTH  read address per requester.
- rd0_gnt / rd1_gnt  out  1  read accepted this cycle (combinational).
- rd0_valid / rd1_valid  out  1  read data valid (registered, 1 cycle after grant).
- rd0_data / rd1_data  out  DATA_WIDTH  read data, qualified by valid.
- ram_we  out  1  to RAM we.
- ram_addr_w  out  ADDR_WIDTH  to RAM addr_w.
- ram_din  out  DATA_WIDTH  to RAM din.
- ram_addr_r  out  ADDR_WIDTH  to RAM addr_r.
- ram_dout  in  DATA_WIDTH  from RAM dout.

Behaviour:
- Reset values: clr_busy=0, clr_done=0, rd0_valid=rd1_valid=0, clear counter=0, write FSM=IDLE, round-robin pointer "last=rd1" (rd0 wins the first tie).
- Read arbitration (round-robin):
  - One request active -> it is granted.
  - Both active -> the requester not granted last wins.
  - Pointer updates only on a grant.
  - The granted address drives ram_addr_r combinationally. No grant -> ram_addr_r=rd0_addr.
  - Grant at cycle T -> rdX_valid=1 at T+1 with rdX_data=ram_dout. Continuous back-to-back grants give one valid per cycle.
  - rdX_data is passthrough of ram_dout; its value is don't-care when valid=0.
  - Requester holds req/addr until gnt. A non-granted requester keeps req high.
- Same-address read and write in the same cycle returns the old data (RAM read-before-write). The arbiter does not forward.
- Write FSM states: IDLE, CLEAR.
  - IDLE, wr_req=1: ram_we=1, ram_addr_w=wr_addr, ram_din=wr_data, wr_ack=1 in the same cycle.
  - IDLE, wr_req=0: ram_we=0.
  - IDLE, clr_start=1: go to CLEAR next cycle; counter=0; clr_busy=1 from next cycle.
  - IDLE, clr_start and wr_req both high: host write is acked that cycle, then CLEAR starts.
  - CLEAR: each cycle ram_we=1, ram_addr_w=counter, ram_din=FILL_VALUE, then counter+1.
  - CLEAR: wr_ack=0, so host writes stall and wr_req must be held.
  - CLEAR: clr_start is ignored.
  - CLEAR, counter==CLEAR_DEPTH-1: write, go to IDLE. clr_busy=0 and clr_done=1 for exactly one cycle on the following cycle.
  - A clear takes exactly CLEAR_DEPTH write cycles.
- Reads remain arbitrated normally during CLEAR; returned data may be pre- or post-clear.
- Counter width is ADDR_WIDTH+1 so CLEAR_DEPTH=2**ADDR_WIDTH terminates without wrap.
- rst_n low mid-clear: immediate return to reset values, no clr_done, RAM partially cleared (contents not restored).
- rst_n low with valid pending: valid is dropped.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: rd0 always wins ties; rd1 is granted only when rd0_req=0; the round-robin pointer is removed.
- Undefined: round-robin as above.

Test Plan:
- Reset then rd0_req=1, rd0_addr=0x081 with RAM preloaded 0x32 at 0x081 -> rd0_gnt same cycle, rd0_valid=1 and rd0_data=0x32 next cycle, rd1_valid=0.
- rd0_req and rd1_req both held for 4 cycles -> grants alternate rd0, rd1, rd0, rd1 and valids alternate one cycle later (with ARB_FIXED_PRIO_EN: rd0 granted all 4, rd1 none).
- Host write wr_addr=0x005, wr_data=0x41, then rd1 read of 0x005 -> wr_ack=1 same cycle, rd1_data=0x41; a same-cycle read of 0x005 returns the old value.
- CLEAR_DEPTH=16, FILL_VALUE=0x20, clr_start pulse -> clr_busy high 16 cycles, ram_addr_w 0..15, clr_done single pulse. Host wr_req held during clear gets wr_ack only after clr_busy falls. Reads 0..15 afterward return 0x20.
- clr_start and wr_req (0x003, 0x11) in the same IDLE cycle -> write acked first, clear starts next cycle, and the later read of 0x003 returns FILL_VALUE.
- rst_n low at clear cycle 7 -> clr_busy=0 immediately, no clr_done. A new clr_start after reset restarts from address 0.
